// File: rtl/add_multicycle.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit digit per clock through a registered carry,
// with valid/ready handshakes on both the operand and result sides.
module add_multicycle #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   generate
      if (CHUNK < 1) begin : g_bad_chunk
         $error("add_multicycle: CHUNK must be >= 1");
      end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
         $error("add_multicycle: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             carry;
   logic [KW-1:0]    k;
   logic [CHUNK-1:0] a_d, b_d, s;
   logic             c, c_msb, last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last      = (k == KW'(N - 1));

   always_comb begin
      a_d = '0;
      b_d = '0;
      for (int i = 0; i < N; i++) begin
         if (k == KW'(i)) begin
            a_d = a_reg[i*CHUNK +: CHUNK];
            b_d = b_reg[i*CHUNK +: CHUNK];
         end
      end
      {c, s} = {1'b0, a_d} + {1'b0, b_d} + {{CHUNK{1'b0}}, carry};
      // carry into the digit's top bit recovered from its sum bit; exact for any CHUNK
      c_msb = s[CHUNK-1] ^ a_d[CHUNK-1] ^ b_d[CHUNK-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         k     <= '0;
         carry <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= sub ? ~b : b;
                  carry <= sub | cin;
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (k == KW'(i)) sum[i*CHUNK +: CHUNK] <= s;
               end
               carry <= c;
               k     <= k + KW'(1);
               if (last) begin
                  cout  <= c;
                  ovf   <= c_msb ^ c;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_multicycle.sv
// Scoreboard bench for add_multicycle: directed cases on the default build plus
// randomized sweeps on three other WIDTH/CHUNK builds against an arithmetic model.
module tb_add_multicycle;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;
   int sweeps_done = 0;
   logic s_rst = 1'b1;

   // result as {ovf, cout, sum zero-extended to 32 bits}
   function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, y,
                                           input logic ci, su);
      logic [63:0] mask, yy, full;
      logic [31:0] s;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      yy   = su ? (~{32'd0, y}) & mask : {32'd0, y};
      full = {32'd0, x} + yy + {63'd0, su | ci};
      s    = full[31:0] & mask[31:0];
      co   = full[w];
      ov   = (x[w-1] == yy[w-1]) && (s[w-1] != x[w-1]);
      return {ov, co, s};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // ---------------- directed DUT, default parameters ----------------
   logic        d_rst, d_in_valid, d_in_ready, d_cin, d_sub;
   logic        d_out_valid, d_out_ready, d_cout, d_ovf;
   logic [15:0] d_a, d_b, d_sum;
   logic [33:0] d_q[$];
   int          d_t[$];
   bit          d_seen = 1'b0;
   logic [33:0] d_e, d_got;
   int          d_tt;

   add_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .reset(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
      .out_valid(d_out_valid), .out_ready(d_out_ready),
      .sum(d_sum), .cout(d_cout), .ovf(d_ovf));

   // called at a negedge; returns at the negedge right after the accepting edge
   task automatic d_issue(input logic [15:0] x, y, input logic ci, su, input logic [33:0] e);
      int g = 0;
      d_a = x; d_b = y; d_cin = ci; d_sub = su; d_in_valid = 1'b1;
      while (!d_in_ready && g < 100) begin @(negedge clk); g++; end
      if (!d_in_ready) chk("d_accept_timeout", 64'(0), 64'(1));
      else begin
         d_q.push_back(e);
         d_t.push_back(cyc + 1);
      end
      @(negedge clk);
      d_in_valid = 1'b0;
   endtask

   task automatic d_drain();
      int g = 0;
      while ((d_q.size() != 0 || d_out_valid) && g < 100) begin @(negedge clk); g++; end
      if (g >= 100) chk("d_drain_timeout", 64'(0), 64'(1));
   endtask

   initial begin : d_mon
      forever begin
         @(negedge clk);
         #1;
         if (d_rst) d_seen = 1'b0;
         else if (d_out_valid) begin
            if (!d_seen) begin
               if (d_q.size() == 0) chk("d_unexpected_result", 64'(1), 64'(0));
               else begin
                  d_e   = d_q.pop_front();
                  d_tt  = d_t.pop_front();
                  d_got = {d_ovf, d_cout, 16'd0, d_sum};
                  chk("d_result", 64'(d_got), 64'(d_e));
                  chk("d_latency", 64'(cyc - d_tt), 64'(4));
               end
            end
            d_seen = !d_out_ready;
         end
      end
   end

   initial begin : d_stim
      logic [15:0] x, y;
      logic        ci, su;
      int          g;
      d_rst = 1'b1; d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
      d_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outputs", 64'({d_out_valid, d_cout, d_ovf, d_sum}), 64'(0));
      chk("rst_in_ready", 64'(d_in_ready), 64'(1));
      d_rst = 1'b0;
      s_rst = 1'b0;
      @(negedge clk);

      // basic add and handshake timing
      d_issue(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 32'h5555});
      for (int i = 0; i < 5; i++) begin
         chk("busy_in_ready", 64'(d_in_ready), 64'(0));
         @(negedge clk);
      end
      chk("idle_in_ready", 64'(d_in_ready), 64'(1));
      d_drain();

      d_issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000}); d_drain();
      d_issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000}); d_drain();
      d_issue(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFE}); d_drain();
      d_issue(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF}); d_drain();

      // backpressure: result held, new operands refused while in DONE
      d_out_ready = 1'b0;
      d_issue(16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 32'h3333});
      g = 0;
      while (!d_out_valid && g < 20) begin @(negedge clk); g++; end
      if (!d_out_valid) chk("bp_valid_timeout", 64'(0), 64'(1));
      d_a = 16'hAAAA; d_b = 16'h5555; d_cin = 1'b1; d_sub = 1'b0; d_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(d_out_valid), 64'(1));
         chk("bp_hold", 64'({d_ovf, d_cout, d_sum}), 64'({2'b00, 16'h3333}));
         chk("bp_in_ready", 64'(d_in_ready), 64'(0));
      end
      d_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(d_in_ready), 64'(1));
      d_issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, {1'b0, 1'b0, 32'h1010});
      d_drain();

      // asynchronous reset between E2 and E3
      d_issue(16'h1234, 16'h1111, 1'b0, 1'b0, ref_add(16, 32'h1234, 32'h1111, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #2 d_rst = 1'b1;
      #1;
      chk("mid_rst_outputs", 64'({d_out_valid, d_cout, d_ovf, d_sum}), 64'(0));
      chk("mid_rst_in_ready", 64'(d_in_ready), 64'(1));
      d_q.delete();
      d_t.delete();
      @(negedge clk);
      d_rst = 1'b0;
      repeat (2) @(negedge clk);
      d_issue(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0100});
      d_drain();

      for (int n = 0; n < 10; n++) begin
         x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom); su = 1'($urandom);
         d_issue(x, y, ci, su, ref_add(16, 32'(x), 32'(y), ci, su));
         d_drain();
      end

      g = 0;
      while (sweeps_done < 3 && g < 80000) begin @(negedge clk); g++; end
      if (sweeps_done < 3) chk("sweep_timeout", 64'(0), 64'(1));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // ---------------- randomized parameter sweep ----------------
   for (genvar gi = 0; gi < 3; gi++) begin : sweep
      localparam int W  = (gi == 2) ? 32 : 16;
      localparam int C  = (gi == 0) ? 16 : ((gi == 1) ? 1 : 8);
      localparam int NN = W / C;

      logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
      logic [W-1:0] a, b, sum;
      logic [33:0]  q[$];
      int           tq[$];
      bit           seen = 1'b0;
      logic [33:0]  e, got;
      int           tt;

      add_multicycle #(.WIDTH(W), .CHUNK(C)) dut (
         .clk(clk), .reset(s_rst), .in_valid(in_valid), .in_ready(in_ready),
         .a(a), .b(b), .cin(cin), .sub(sub),
         .out_valid(out_valid), .out_ready(out_ready),
         .sum(sum), .cout(cout), .ovf(ovf));

      initial begin : stim
         int g;
         in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
         @(negedge clk);
         while (s_rst) @(negedge clk);
         for (int n = 0; n < 1000; n++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 200) begin @(negedge clk); g++; end
            if (!in_ready) chk("sw_accept_timeout", 64'(0), 64'(1));
            else begin
               q.push_back(ref_add(W, 32'(a), 32'(b), cin, sub));
               tq.push_back(cyc + 1);
            end
            @(negedge clk);
            in_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
         end
         g = 0;
         while ((q.size() != 0 || out_valid) && g < 500) begin @(negedge clk); g++; end
         if (g >= 500) chk("sw_drain_timeout", 64'(0), 64'(1));
         sweeps_done++;
      end

      initial begin : mon
         out_ready = 1'b0;
         forever begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (s_rst) seen = 1'b0;
            else if (out_valid) begin
               if (!seen) begin
                  if (q.size() == 0) chk("sw_unexpected_result", 64'(1), 64'(0));
                  else begin
                     e   = q.pop_front();
                     tt  = tq.pop_front();
                     got = {ovf, cout, 32'(sum)};
                     chk("sw_result", 64'(got), 64'(e));
                     chk("sw_latency", 64'(cyc - tt), 64'(NN));
                  end
               end
               seen = !out_ready;
            end
         end
      end
   end
endmodule

// File: doc/add_multicycle.md
# add_multicycle

Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands one CHUNK-bit digit per clock, carrying between digits through a registered carry. It is the sequential, width-generic successor to the fixed 4-bit ripple adder and is intended for datapaths that trade latency for a short combinational carry path. Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake that holds its data under backpressure.

## Interface
- WIDTH, default 16: operand and result width in bits.
- CHUNK, default 4: bits added per cycle. Constraints: CHUNK ≥ 1 and WIDTH % CHUNK == 0. Any other value must cause an elaboration error.
- N (derived, not overridable): WIDTH/CHUNK, the number of cycles in RUN.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  1 selects A − B, computed as A + ~B + 1.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In subtract mode, 0 means a borrow occurred.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid && in_ready at a rising edge:
    - capture a into the A register;
    - capture b into the B register, or ~b when sub=1;
    - load the carry register with cin, or 1 when sub=1;
    - clear the digit index k to 0;
    - go to RUN.
- RUN
  - Each edge computes {c, s} = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry.
  - It writes s into sum[k*CHUNK +: CHUNK], sets carry←c, and increments k.
  - On the edge that processes k = N−1, it also latches cout←c and ovf←(carry into bit WIDTH−1) XOR c, then goes to DONE.
- DONE
  - out_valid=1.
  - sum, cout and ovf are held stable while out_ready=0.
  - When out_ready=1 at an edge, go to IDLE. sum, cout and ovf keep their values; they are only defined while out_valid=1.
- in_ready is a combinational decode of state: (state==IDLE).
- Changes on a, b, cin and sub after capture have no effect on the operation in flight.
- in_valid outside IDLE is ignored. No queueing.
- Arithmetic is modulo 2^WIDTH. The result equals (a + b + cin) or (a + ~b + 1) truncated to WIDTH bits, with cout as bit WIDTH.
- ovf computation when CHUNK=1 or N=1: the carry into the MSB is taken inside the final digit's addition. It must be exact for every legal CHUNK.
- Reset, asynchronous, at any time including mid-RUN or in DONE:
  - state←IDLE, k←0, carry←0;
  - sum←0, cout←0, ovf←0, out_valid←0;
  - in_ready reads 1.
  - The aborted operation produces no output.
  - No capture occurs while reset is high.

## Timing
- Latency: an operation accepted at edge E0 processes digits at edges E1..EN, and out_valid rises after edge EN.
- A result consumed at edge EN+1 (out_ready held high) returns the block to IDLE. The next accept can happen at EN+2.
- Peak throughput is one operation per N+2 cycles.
- The combinational critical path is one CHUNK-bit add plus the carry mux. It is independent of WIDTH.
- out_valid, in_ready, sum, cout and ovf are glitch-free register or state decodes. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Basic add, defaults: a=0x1234, b=0x4321, cin=0, sub=0.
  - Required: sum=0x5555, cout=0, ovf=0.
  - out_valid high in the 4th cycle after accept, and in_ready low for exactly cycles E0+1..E5.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1.
  - Required: sum=0x0000, cout=1, ovf=0.
  - Also: a=0x7FFF, b=0x0001 gives sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored).
  - Required: sum=0xFFFE, cout=0, ovf=0.
  - Also: a=0x8000, b=0x0001, sub=1 gives sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: out_valid, sum, cout and ovf constant; in_ready=0; the new operands are not accepted.
  - After out_ready=1, the next operation computes from operands presented after return to IDLE.
- Reset mid-RUN: assert reset asynchronously between E2 and E3.
  - Required: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 immediately.
  - The following operation 0x00FF+0x0001 gives 0x0100.
- Parameter sweep: configurations (WIDTH,CHUNK) = (16,16), (16,1) and (32,8), each with 1000 random a/b/cin/sub vectors checked against a behavioural model.
  - Required: exact sum, cout and ovf for every vector, and latency of N cycles.
